uart_rx_cmd: RTL and testbench

- 8N1 UART receiver. Deserialises the asynchronous serial line into command bytes.
- Sits directly upstream of the PWM LED driver and drives its command[7:0] and rx_valid inputs.
- Each accepted byte is presented on rx_data together with a one-cycle rx_valid strobe.
- Bit 7 of the byte is ignored downstream; bits 6:4 carry colour and bits 3:0 carry brightness.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx_cmd.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_cmd.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART command receiver.
package uart_pkg;

  // Data bits per frame.
  localparam int unsigned DATA_BITS = 8;

  // Receiver FSM states; StParity is only reachable when UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Clocks per serial bit, truncated.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
  parameter int unsigned     Width    = 1,
  parameter logic [Width-1:0] ResetVal = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two back-to-back flops resolve metastability before the value is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver producing command bytes with a one-cycle valid strobe.
// Optional even-parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_cmd #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  import uart_pkg::*;

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      IdxLast = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_rx_cmd: CLK_FREQ/BAUD must be at least 4");
  end

  logic rx_s;

  sync_2ff #(
    .Width   (1),
    .ResetVal(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx_i),
    .q_o  (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 armed_q, armed_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Next-state logic: sample mid-bit, shift LSB first, judge the frame at mid stop bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    armed_d = armed_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Only a high-to-low transition after an idle-high line starts a frame.
        if (armed_q && !rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
          armed_d = 1'b0;
        end else if (rx_s) begin
          armed_d = 1'b1;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StIdle;
`ifdef UART_RX_PARITY_EN
          if (rx_s && !(^{shift_q, par_q})) begin
`else
          if (rx_s) begin
`endif
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed self-checking bench for uart_rx_cmd at 10 clocks per bit.
module tb_uart_rx_cmd;

  localparam int unsigned Cpb = 10;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned ExpLat = 108;
`else
  localparam int unsigned ExpLat = 98;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_cmd #(
    .CLK_FREQ(1000000),
    .BAUD    (100000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .frame_err_o(frame_err),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cyc = 0;
  int         vcyc = 0;
  int         ferr_n = 0;
  int         both_n = 0;
  logic [7:0] vq[$];
  int         checks = 0;
  int         passed = 0;
  int         start_cyc = 0;
  logic       last_par;

  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      vq.push_back(rx_data);
      vcyc <= cyc;
    end
    if (frame_err) ferr_n <= ferr_n + 1;
    if (rx_valid && frame_err) both_n <= both_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drives one frame from a negedge; line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (Cpb) @(negedge clk);
    end
    last_par = par_b;
`ifdef UART_RX_PARITY_EN
    rx = par_b;
    repeat (Cpb) @(negedge clk);
`endif
    rx = stop_b;
    repeat (Cpb) @(negedge clk);
  endtask

  int nv;
  int nf;
  int lat;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte 0x5A.
    nv = vq.size();
    nf = ferr_n;
    send_frame(8'h5A, 1'b1, ^8'h5A);
    repeat (5) @(negedge clk);
    lat = vcyc - start_cyc;
    check("5a_valid_count", vq.size() - nv, 1);
    check("5a_data", rx_data, 8'h5A);
    check("5a_latency_window", (lat >= ExpLat - 1) && (lat <= ExpLat + 1), 1'b1);
    check("5a_no_frame_err", ferr_n - nf, 0);
    check("5a_colour", rx_data[6:4], 3'd5);
    check("5a_brightness", rx_data[3:0], 4'd10);

    // Back-to-back frames with one stop bit each.
    nv = vq.size();
    nf = ferr_n;
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h7F, 1'b1, ^8'h7F);
    repeat (5) @(negedge clk);
    check("b2b_valid_count", vq.size() - nv, 3);
    if (vq.size() - nv == 3) begin
      check("b2b_byte0", vq[nv], 8'h00);
      check("b2b_byte1", vq[nv+1], 8'hFF);
      check("b2b_byte2", vq[nv+2], 8'h7F);
    end
    check("b2b_no_frame_err", ferr_n - nf, 0);

    // 3-clock glitch aborts in START.
    nv = vq.size();
    nf = ferr_n;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_cleared", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("glitch_no_valid", vq.size() - nv, 0);
    check("glitch_no_frame_err", ferr_n - nf, 0);

    // Low stop bit, line held low, then recovery.
    nv = vq.size();
    nf = ferr_n;
    send_frame(8'h33, 1'b0, ^8'h33);
    repeat (50) @(negedge clk);
    check("ferr_pulse_count", ferr_n - nf, 1);
    check("ferr_no_valid", vq.size() - nv, 0);
    check("ferr_data_held", rx_data, 8'h7F);
    check("ferr_no_retrigger", busy, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h44, 1'b1, ^8'h44);
    repeat (5) @(negedge clk);
    check("recover_valid_count", vq.size() - nv, 1);
    check("recover_data", rx_data, 8'h44);

    // Reset during data bit 4 of 0xA5.
    nv = vq.size();
    nf = ferr_n;
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hA5 >> i);
      repeat (Cpb) @(negedge clk);
    end
    rx = 1'(8'hA5 >> 4);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_busy", busy, 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_strobe", vq.size() - nv, 0);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    repeat (5) @(negedge clk);
    check("midrst_c3_count", vq.size() - nv, 1);
    check("midrst_c3_data", rx_data, 8'hC3);
    check("midrst_no_frame_err", ferr_n - nf, 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x5A with parity 0 passes, 0x5B with parity 0 fails.
    nv = vq.size();
    nf = ferr_n;
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("par_ok_count", vq.size() - nv, 1);
    check("par_ok_data", rx_data, 8'h5A);
    send_frame(8'h5B, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("par_bad_ferr", ferr_n - nf, 1);
    check("par_bad_no_valid", vq.size() - nv, 1);
    check("par_bad_data_held", rx_data, 8'h5A);
`endif

    check("valid_ferr_exclusive", both_n, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
